// File: rtl/mips_defs.sv
// Shared definitions for the MIPS register-destination logic.
//   reg_dst_e    : encoding of the decoder's reg_dst control field
//   DEF_ADDR_W   : default register address width
//   DEF_LINK_REG : register written by jump-and-link
package mips_defs;

   typedef enum logic [1:0] {
      RD_RT   = 2'b00,
      RD_RD   = 2'b01,
      RD_LINK = 2'b10,
      RD_RSVD = 2'b11
   } reg_dst_e;

   localparam int DEF_ADDR_W   = 5;
   localparam int DEF_LINK_REG = 31;

endpackage

// File: rtl/dst_stage_reg.sv
// One pipeline slot holding an in-flight register write {addr, valid}.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   load             : capture d_addr/d_valid on this edge
//   bubble           : load an empty slot {0, invalid}; wins over load
//   d_addr, d_valid  : incoming destination and its valid flag
//   q_addr, q_valid  : registered slot contents
module dst_stage_reg
   import mips_defs::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              bubble,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic              d_valid,
   output logic [ADDR_W-1:0] q_addr,
   output logic              q_valid
);

   logic [ADDR_W-1:0] addr_d, addr_q;
   logic              valid_d, valid_q;

   always_comb begin
      addr_d  = addr_q;
      valid_d = valid_q;
      if (bubble) begin
         addr_d  = '0;
         valid_d = 1'b0;
      end else if (load) begin
         addr_d  = d_addr;
         valid_d = d_valid;
      end
   end

   // NOTE: state is updated with non-blocking assignments so every slot
   // samples its neighbour's pre-edge value and the chain shifts by one.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         addr_q  <= addr_d;
         valid_q <= valid_d;
      end
   end

   assign q_addr  = addr_q;
   assign q_valid = valid_q;

endmodule

// File: rtl/regdst_pipe.sv
// Write-destination select plus a short tracking pipeline of in-flight
// register writes, with youngest-match hazard/forward reporting.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   addr_1, addr_2       : rt / rd fields of the decode instruction
//   reg_dst              : 00 rt, 01 rd, 10 link, 11 reserved
//   reg_write            : decode instruction writes a register
//   stall, flush         : bubble stage 0 (stall re-presents, flush squashes)
//   src_a, src_b         : decode source operands (rs, rt)
//   write_addr           : combinational selected destination
//   wb_addr, wb_en       : destination/enable of the last stage
//   hazard_a/b           : source matches a valid in-flight destination
//   fwd_sel_a/b          : 0 none, k = youngest matching stage is k-1
//   illegal_dst          : sticky flag, a reserved reg_dst was captured
// STAGES must be >= 2 and 2**FWD_W >= STAGES+1.
module regdst_pipe
   import mips_defs::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int STAGES   = 3,
   parameter int LINK_REG = DEF_LINK_REG,
   parameter int FWD_W    = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr_1,
   input  logic [ADDR_W-1:0] addr_2,
   input  logic [1:0]        reg_dst,
   input  logic              reg_write,
   input  logic              stall,
   input  logic              flush,
   input  logic [ADDR_W-1:0] src_a,
   input  logic [ADDR_W-1:0] src_b,
   output logic [ADDR_W-1:0] write_addr,
   output logic [ADDR_W-1:0] wb_addr,
   output logic              wb_en,
   output logic              hazard_a,
   output logic              hazard_b,
   output logic [FWD_W-1:0]  fwd_sel_a,
   output logic [FWD_W-1:0]  fwd_sel_b,
   output logic              illegal_dst
);

   reg_dst_e          dst_sel;
   logic              entry_valid;
   logic              capture;
   logic              illegal_dst_d, illegal_dst_q;

   logic [ADDR_W-1:0] stage_addr  [STAGES];
   logic              stage_valid [STAGES];
   logic [ADDR_W-1:0] in_addr     [STAGES];
   logic              in_valid    [STAGES];

   assign dst_sel = reg_dst_e'(reg_dst);

   // NOTE: every output of a combinational block gets a default first, so
   // no path through the case leaves it unassigned and infers a latch.
   always_comb begin
      write_addr = '0;
      case (dst_sel)
         RD_RT:   write_addr = addr_1;
         RD_RD:   write_addr = addr_2;
         RD_LINK: write_addr = ADDR_W'(LINK_REG);
         default: write_addr = '0;
      endcase
   end

   // r0 is hard-wired zero, so writes to it are dropped before tracking.
   assign entry_valid = reg_write && (dst_sel != RD_RSVD) && (write_addr != '0);

   // A normal capture is the only event that consumes the decode instruction.
   assign capture = !stall && !flush;

   always_comb begin
      illegal_dst_d = illegal_dst_q;
      if (capture && dst_sel == RD_RSVD) begin
         illegal_dst_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         illegal_dst_q <= 1'b0;
      end else begin
         illegal_dst_q <= illegal_dst_d;
      end
   end

   assign illegal_dst = illegal_dst_q;

   // Stage 0 takes the decode instruction (or a bubble); later stages always
   // advance, so an older write is never held behind a stall.
   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      if (i == 0) begin : g_head
         assign in_addr[i]  = write_addr;
         assign in_valid[i] = entry_valid;
      end else begin : g_tail
         assign in_addr[i]  = stage_addr[i-1];
         assign in_valid[i] = stage_valid[i-1];
      end

      dst_stage_reg #(
         .ADDR_W (ADDR_W)
      ) u_reg (
         .clk     (clk),
         .rst     (rst),
         .load    (1'b1),
         .bubble  ((i == 0) && !capture),
         .d_addr  (in_addr[i]),
         .d_valid (in_valid[i]),
         .q_addr  (stage_addr[i]),
         .q_valid (stage_valid[i])
      );
   end

   assign wb_addr = stage_addr[STAGES-1];
   assign wb_en   = stage_valid[STAGES-1];

   // Scan from oldest to youngest so the youngest match overwrites the result.
   always_comb begin
      hazard_a  = 1'b0;
      hazard_b  = 1'b0;
      fwd_sel_a = '0;
      fwd_sel_b = '0;
      for (int k = STAGES - 1; k >= 0; k--) begin
         if (src_a != '0 && stage_valid[k] && stage_addr[k] == src_a) begin
            hazard_a  = 1'b1;
            fwd_sel_a = FWD_W'(k + 1);
         end
         if (src_b != '0 && stage_valid[k] && stage_addr[k] == src_b) begin
            hazard_b  = 1'b1;
            fwd_sel_b = FWD_W'(k + 1);
         end
      end
   end

endmodule

// File: doc/regdst_pipe.md
Name: regdst_pipe

Overview:
- Parametrised successor to the single-cycle write-destination mux in the MIPS datapath.
- Selects the destination register among rt, rd and the link register (JAL). Carries destination address and write-enable through STAGES pipeline registers (EX..WB).
- Reports youngest-match hazard/forward information for the two decode-stage source operands.
- Sits between the decoder/control unit and the register file write port.

Parameters:
ADDR_W, 5, register address width
STAGES, 3, number of tracked pipeline stages after decode (minimum 2)
LINK_REG, 31, destination used when reg_dst = link
FWD_W, 2, width of forward-select outputs; must satisfy 2^FWD_W >= STAGES+1

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
addr_1  in  ADDR_W  rt field of instruction in decode
addr_2  in  ADDR_W  rd field of instruction in decode
reg_dst  in  2  00 = rt, 01 = rd, 10 = link, 11 = reserved
reg_write  in  1  decode instruction writes a register
stall  in  1  hold decode; insert bubble into stage 0
flush  in  1  squash the instruction entering stage 0
src_a  in  ADDR_W  rs of decode instruction
src_b  in  ADDR_W  rt of decode instruction
write_addr  out  ADDR_W  combinational selected destination for the decode instruction
wb_addr  out  ADDR_W  destination in last stage (STAGES-1)
wb_en  out  1  register-file write enable from last stage
hazard_a  out  1  src_a matches a valid in-flight destination
hazard_b  out  1  src_b matches a valid in-flight destination
fwd_sel_a  out  FWD_W  0 = none; k = youngest matching stage is k-1
fwd_sel_b  out  FWD_W  as fwd_sel_a, for src_b
illegal_dst  out  1  sticky: reg_dst = 11 was accepted

Behaviour:
- Selection (combinational):
  - write_addr = addr_1, addr_2, or LINK_REG, per reg_dst.
  - reg_dst = 11 drives write_addr = 0.
- Stage entry valid = reg_write AND reg_dst != 11 AND write_addr != 0. Writes to r0 are never tracked or committed.
- Each rising clk edge, priority rst > flush > stall > normal:
  - rst: all stage addr = 0, valid = 0, illegal_dst = 0.
  - flush: stage0 <= {0, valid 0}; stages 1..STAGES-1 shift.
  - stall: stage0 <= bubble {0, valid 0}; stages 1..STAGES-1 shift. The decode instruction is not captured and is re-presented next cycle.
  - normal: stage0 <= {write_addr, entry valid}; stage[i] <= stage[i-1].
- Later stages are never held. stall and flush affect stage 0 only.
- illegal_dst sets only on a normal (non-stall, non-flush) capture with reg_dst = 11. It is cleared only by rst.
- Latency:
  - The decode instruction appears on wb_addr/wb_en exactly STAGES cycles after capture.
  - wb_en = valid of stage STAGES-1. wb_addr = its addr. Both are registered.
- Hazard and forward (combinational from registered state plus src inputs):
  - A match at stage k requires valid[k] AND addr[k] == src AND src != 0.
  - hazard_x = OR over all stages.
  - fwd_sel_x = (lowest matching k) + 1, else 0. The youngest match wins when several stages match.
  - The decode instruction's own destination is never compared.
- Reset values: wb_addr = 0, wb_en = 0, hazard_a/b = 0, fwd_sel_a/b = 0, illegal_dst = 0.
- Reset mid-operation clears all in-flight writes. No write commits on the cycle after rst.

Decomposition:
- Shared package/header `mips_defs`:
  - reg_dst encodings (RD_RT, RD_RD, RD_LINK, RD_RSVD)
  - default ADDR_W = 5
  - LINK_REG = 31
- Sub-module `dst_stage_reg`: one {addr, valid} register with sync rst, load and bubble inputs. Instantiate STAGES times via generate.
- Match/priority encoder logic stays inline.

Test Plan:
- Reset: rst = 1 for 2 cycles with reg_write = 1, addr_2 = 7, reg_dst = 01 -> wb_en = 0, fwd_sel_a = 0, illegal_dst = 0 on the cycle after release.
- Select and latency: capture reg_dst = 00/01/10 with addr_1 = 4, addr_2 = 9 over three consecutive cycles -> wb_addr = 4, 9, 31 with wb_en = 1, arriving 3 cycles after each capture (STAGES = 3).
- Forward priority: stage0 dest 5, stage2 dest 5, src_a = 5 -> hazard_a = 1, fwd_sel_a = 1. Stage0 invalid, same setup -> fwd_sel_a = 3.
- r0 and reserved: reg_dst = 00, addr_1 = 0, reg_write = 1 -> no hazard for src_a = 0, wb_en = 0 three cycles later. reg_dst = 11 -> illegal_dst = 1 and stays set.
- Stall/flush: stall = 1 for one cycle while the decode instruction targets 12 -> bubble in stage0, older stages advance, 12 enters one cycle later. flush and stall together -> flush taken, stage0 invalid.
- Mid-operation reset: three valid writes in flight, assert rst -> wb_en = 0 for every following cycle until a new capture reaches the last stage.
